// File: rtl/led_pkg.sv
// led_pkg: shared constants and FSM state type for led_frame_serializer
// and its shift-register sub-module.
package led_pkg;

   localparam int LED_WORD_W      = 16;   // bits per grey-level word
   localparam int LED_FRAME_WORDS = 512;  // words per frame (one display bank)
   localparam int LED_CNT_W       = 9;    // width of the per-frame word counter

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } ledser_state_t;

endpackage

// File: rtl/ledser_piso.sv
// ledser_piso: parallel-load, right-shift register. Bit 0 is presented on
// q0; each shift moves the word one place towards bit 0 and fills the top
// with zero. Load has priority over shift.
module ledser_piso
   import led_pkg::*;
#(
   parameter int WIDTH = LED_WORD_W
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             q0
);

   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shreg_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
         if (gi == WIDTH - 1) begin : g_top
            assign shreg_next[gi] = load ? d[gi] : (shift ? 1'b0 : shreg_reg[gi]);
         end else begin : g_mid
            assign shreg_next[gi] = load ? d[gi] : (shift ? shreg_reg[gi+1] : shreg_reg[gi]);
         end
      end
   endgenerate

   // Shift stage; reset discards any partially sent word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_reg <= '0;
      end else begin
         shreg_reg <= shreg_next;
      end
   end

   assign q0 = shreg_reg[0];

endmodule

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: accepts words over valid/ready and sends each one
// LSB-first on dai with den high for WORD_W cycles, then GAP den-low cycles.
// Counts completed words per frame and pulses frame_done on the wrap.
// Optional build macro LEDSER_LAST_CHECK_EN enables the s_last alignment
// check driving the sticky sync_err flag; without it sync_err is tied low.
module led_frame_serializer
   import led_pkg::*;
#(
   parameter int WORD_W      = LED_WORD_W,
   parameter int FRAME_WORDS = LED_FRAME_WORDS,
   parameter int GAP         = 2
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WORD_W-1:0]    s_data,
   input  logic                 s_last,
   output logic                 den,
   output logic                 dai,
   output logic [LED_CNT_W-1:0] word_cnt,
   output logic                 frame_done,
   output logic                 sync_err
);

   localparam int BIT_W = $clog2(WORD_W);
   localparam int GAP_W = $clog2(GAP);   // GAP is at least 2, so GAP_W >= 1
   localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP - 1);
   localparam logic [LED_CNT_W-1:0] WORD_LAST = LED_CNT_W'(FRAME_WORDS - 1);

   ledser_state_t    state_reg;
   ledser_state_t    state_next;
   logic [BIT_W-1:0] bit_cnt_reg;
   logic [GAP_W-1:0] gap_cnt_reg;
   logic             shifting;
   logic             accept;
   logic             last_bit;
   logic             gap_end;
   logic             q0;

   assign gap_end  = (gap_cnt_reg == GAP_LAST);
   assign accept   = s_valid & s_ready;
   assign last_bit = shifting & (bit_cnt_reg == BIT_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: a word accepted in the last gap cycle starts straight away.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (accept) state_next = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_next = ST_GAP;
         ST_GAP: begin
            if (accept) begin
               state_next = ST_SHIFT;
            end else if (gap_end) begin
               state_next = ST_IDLE;
            end
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output decode: s_ready depends only on state and gap count, never s_valid.
   always_comb begin
      s_ready  = 1'b0;
      shifting = 1'b0;
      case (state_reg)
         ST_IDLE:  s_ready  = 1'b1;
         ST_SHIFT: shifting = 1'b1;
         ST_GAP:   s_ready  = gap_end;
         default:  s_ready  = 1'b0;
      endcase
   end

   // Bit position within the burst and position within the gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_reg <= '0;
         gap_cnt_reg <= '0;
      end else begin
         if (accept) begin
            bit_cnt_reg <= '0;
         end else if (shifting) begin
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
         end
         if (last_bit) begin
            gap_cnt_reg <= '0;
         end else if (state_reg == ST_GAP && !gap_end) begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
         end
      end
   end

   ledser_piso #(
      .WIDTH (WORD_W)
   ) u_piso (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shifting),
      .d     (s_data),
      .q0    (q0)
   );

   // Registered serial outputs; dai is forced low outside a burst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         den <= 1'b0;
         dai <= 1'b0;
      end else begin
         den <= shifting;
         dai <= shifting & q0;
      end
   end

   // Word counter: advances with the last data bit, wrapping at the bank size.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (last_bit) begin
            if (word_cnt == WORD_LAST) begin
               word_cnt   <= '0;
               frame_done <= 1'b1;
            end else begin
               word_cnt <= word_cnt + LED_CNT_W'(1);
            end
         end
      end
   end

`ifdef LEDSER_LAST_CHECK_EN
   // Sticky alignment error: s_last must mark exactly the final word slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_err <= 1'b0;
      end else if (accept && (s_last != (word_cnt == WORD_LAST))) begin
         sync_err <= 1'b1;
      end
   end
`else
   logic unused_last;
   assign unused_last = s_last;
   assign sync_err    = 1'b0;
`endif

endmodule

// File: tb/tb_led_frame_serializer.sv
// tb_led_frame_serializer: directed and randomized stimulus for
// led_frame_serializer, checked against a word-level reference model and a
// capture model of the downstream controller. Honors LEDSER_LAST_CHECK_EN.
module tb_led_frame_serializer;

   localparam int FW = 512;
`ifdef LEDSER_LAST_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        s_last;
   logic        den;
   logic        dai;
   logic [8:0]  word_cnt;
   logic        frame_done;
   logic        sync_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference model state
   logic [15:0] exp_q[$];
   int          den_rises[$];
   int          pos      = 0;     // frame slot of the next accepted word
   logic        exp_err  = 1'b0;
   int          last_acc = 0;
   int          rdy_cnt  = 0;
   int          fd_count = 0;
   int          nwords   = 0;

   // monitor state
   int          run  = 0;
   int          mcnt = 0;
   logic [31:0] acc  = '0;
   logic        exp_fd;
   logic [15:0] w;

   led_frame_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .den        (den),
      .dai        (dai),
      .word_cnt   (word_cnt),
      .frame_done (frame_done),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Offer one word and wait for the handshake; leaves s_valid high so a
   // following call streams back-to-back.
   task automatic send(input logic [15:0] wd, input logic last);
      int t = 0;
      s_valid = 1'b1;
      s_data  = wd;
      s_last  = last;
      while (s_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", (t < 200), 1);
      if (t < 200) begin
         @(posedge clk);
         #1;
         exp_q.push_back(wd);
         last_acc = cyc;
         if (CHECK_EN && (last != (pos == FW - 1))) exp_err = 1'b1;
         pos = (pos + 1) % FW;
      end else begin
         s_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      while ((exp_q.size() != 0 || den !== 1'b0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_wait", (t < 200), 1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      exp_q.delete();
      pos     = 0;
      exp_err = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Controller capture model plus word-count / frame model, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         run  = 0;
         acc  = '0;
         mcnt = 0;
      end else begin
         if (s_ready === 1'b1) rdy_cnt++;
         exp_fd = 1'b0;
         if (den === 1'b1) begin
            if (run == 0) den_rises.push_back(cyc);
            if (run < 32) acc[run] = dai;
            if (run == 15) begin
               exp_fd = (mcnt == FW - 1);
               mcnt   = (mcnt + 1) % FW;
            end
            run++;
         end else begin
            chk("dai_idle", dai, 0);
            if (run != 0) begin
               chk("burst_len", run, 16);
               chk("burst_expected", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk("captured_word", acc, {16'h0, w});
                  nwords++;
                  $display("word %0d captured %h (word_cnt %0d)", nwords, acc[15:0], word_cnt);
               end
               run = 0;
               acc = '0;
            end
         end
         chk("frame_done", frame_done, exp_fd);
         if (frame_done === 1'b1) fd_count++;
         chk("word_cnt", word_cnt, mcnt);
         chk("sync_err", sync_err, exp_err);
      end
   end

   initial begin
      int exp_bits[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
      int a1, a2, a3, r0, d0, n0, fd0;

      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;

      // reset values
      #1;
      chk("rst_den", den, 0);
      chk("rst_dai", dai, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_s_ready", s_ready, 1);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b0;

      // single word 0xA5C3: latency, bit order, gap
      send(16'hA5C3, 1'b0);
      s_valid = 1'b0;
      @(negedge clk);
      chk("lat_den_before", den, 0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("a5c3_den", den, 1);
         chk("a5c3_dai", dai, exp_bits[k]);
      end
      chk("a5c3_word_cnt", word_cnt, 1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("idle_den_low", den, 0);
      end
      chk("idle_s_ready", s_ready, 1);

      // back-to-back stream with s_valid held high
      r0 = rdy_cnt;
      d0 = den_rises.size();
      n0 = nwords;
      send(16'h0001, 1'b0);
      a1 = last_acc;
      r0 = rdy_cnt;
      send(16'h8000, 1'b0);
      a2 = last_acc;
      send(16'hFFFF, 1'b0);
      a3 = last_acc;
      chk("stream_ready_cycles", rdy_cnt - r0, 2);
      drain();
      chk("stream_period_1", a2 - a1, 18);
      chk("stream_period_2", a3 - a2, 18);
      chk("den_rises", den_rises.size() - d0, 3);
      if (den_rises.size() >= d0 + 3) begin
         chk("den_period_1", den_rises[d0+1] - den_rises[d0], 18);
         chk("den_period_2", den_rises[d0+2] - den_rises[d0+1], 18);
      end
      chk("stream_words", nwords - n0, 3);

      // random gaps of 0..20 idle cycles between words
      for (int i = 0; i < 40; i++) begin
         int g;
         g = $urandom_range(0, 20);
         if (g > 0) begin
            s_valid = 1'b0;
            repeat (g) @(negedge clk);
         end
         send(16'($urandom), 1'b0);
      end
      drain();

      // reset during bit 7 of word 3, then restart at word_cnt 0
      do_reset();
      for (int i = 0; i < 4; i++) send(16'($urandom), 1'b0);
      @(negedge clk);
      repeat (8) @(negedge clk);
      chk("word3_in_burst", den, 1);
      #1;
      rst     = 1'b1;
      s_valid = 1'b0;
      exp_q.delete();
      pos     = 0;
      exp_err = 1'b0;
      #1;
      chk("midrst_den", den, 0);
      chk("midrst_dai", dai, 0);
      chk("midrst_word_cnt", word_cnt, 3'd0);
      chk("midrst_s_ready", s_ready, 1);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      chk("post_rst_word_cnt", word_cnt, 0);
      send(16'h1234, 1'b0);
      s_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("w1234_word_cnt", word_cnt, 1);
      drain();

      // full frame with s_last on word 511
      do_reset();
      fd0 = fd_count;
      for (int i = 0; i < FW; i++) send(16'($urandom), (i == FW - 1));
      drain();
      chk("frame_done_count", fd_count - fd0, 1);
      chk("frame_wrap_word_cnt", word_cnt, 0);
      chk("frame_sync_err", sync_err, 0);

      // misplaced s_last on word 100
      do_reset();
      for (int i = 0; i < FW; i++) begin
         send(16'($urandom), (i == 100));
         if (i == 100) begin
            @(negedge clk);
            chk("sync_err_after_100", sync_err, CHECK_EN);
         end
      end
      drain();
      chk("sync_err_frame_end", sync_err, CHECK_EN);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
